// File: rtl/bounding_box_tracker.sv
// Bounding-box tracker: accumulates per-label min/max extents over a frame,
// then streams one record per touched label (ascending order) over a
// valid/ready port, clears the table and returns to accumulation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_ACCUM | pixels update the label table; frame_end starts the dump
// S_DUMP  | scan pointer walks labels 1..MAX_LABELS-1 emitting records
// S_CLEAR | table invalidated, dump_done pulsed, back to S_ACCUM
module bounding_box_tracker #(
  parameter int LABEL_W    = 8,
  parameter int COORD_W    = 11,
  parameter int MAX_LABELS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [LABEL_W-1:0] label,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               frame_end,
  output logic               box_valid,
  input  logic               box_ready,
  output logic [LABEL_W-1:0] box_label,
  output logic [COORD_W-1:0] box_xmin,
  output logic [COORD_W-1:0] box_xmax,
  output logic [COORD_W-1:0] box_ymin,
  output logic [COORD_W-1:0] box_ymax,
  output logic               dump_done,
  output logic               overrun
);

  localparam int IDX_W = $clog2(MAX_LABELS);
  // One extra bit so the pointer can sit past the last label while the
  // final record waits for acceptance.
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {S_ACCUM, S_DUMP, S_CLEAR} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               box_valid_q, box_valid_d;
  logic [LABEL_W-1:0] box_label_q, box_label_d;
  logic [COORD_W-1:0] box_xmin_q, box_xmin_d;
  logic [COORD_W-1:0] box_xmax_q, box_xmax_d;
  logic [COORD_W-1:0] box_ymin_q, box_ymin_d;
  logic [COORD_W-1:0] box_ymax_q, box_ymax_d;
  logic               dump_done_q, dump_done_d;
  logic               overrun_q, overrun_d;

  logic [MAX_LABELS-1:0] valid_q;
  logic [COORD_W-1:0]    xmin_q [MAX_LABELS];
  logic [COORD_W-1:0]    xmax_q [MAX_LABELS];
  logic [COORD_W-1:0]    ymin_q [MAX_LABELS];
  logic [COORD_W-1:0]    ymax_q [MAX_LABELS];

  logic             label_in_range;
  logic             pix_hit;
  logic [IDX_W-1:0] pix_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             can_adv;

  assign label_in_range = (32'(label) < 32'(MAX_LABELS));
  assign pix_hit  = (state_q == S_ACCUM) && en && (label != '0) && label_in_range;
  assign pix_idx  = label[IDX_W-1:0];
  assign scan_idx = ptr_q[IDX_W-1:0];
  // The pointer may move only when no record is stuck waiting downstream.
  assign can_adv  = !box_valid_q || box_ready;

  // Label valid bits: set on first pixel of a label, wiped in CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (state_q == S_CLEAR) begin
      valid_q <= '0;
    end else if (pix_hit) begin
      valid_q[pix_idx] <= 1'b1;
    end
  end

  // Extent storage: first pixel seeds all four extents, later pixels widen them.
  always_ff @(posedge clk) begin
    if (pix_hit) begin
      if (!valid_q[pix_idx]) begin
        xmin_q[pix_idx] <= x;
        xmax_q[pix_idx] <= x;
        ymin_q[pix_idx] <= y;
        ymax_q[pix_idx] <= y;
      end else begin
        if (x < xmin_q[pix_idx]) xmin_q[pix_idx] <= x;
        if (x > xmax_q[pix_idx]) xmax_q[pix_idx] <= x;
        if (y < ymin_q[pix_idx]) ymin_q[pix_idx] <= y;
        if (y > ymax_q[pix_idx]) ymax_q[pix_idx] <= y;
      end
    end
  end

  // FSM state, scan pointer and output record registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ACCUM;
      ptr_q       <= PTR_W'(1);
      box_valid_q <= 1'b0;
      box_label_q <= '0;
      box_xmin_q  <= '0;
      box_xmax_q  <= '0;
      box_ymin_q  <= '0;
      box_ymax_q  <= '0;
      dump_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      box_valid_q <= box_valid_d;
      box_label_q <= box_label_d;
      box_xmin_q  <= box_xmin_d;
      box_xmax_q  <= box_xmax_d;
      box_ymin_q  <= box_ymin_d;
      box_ymax_q  <= box_ymax_d;
      dump_done_q <= dump_done_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: dump scan with stall/skip/back-to-back load handling.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    box_valid_d = box_valid_q;
    box_label_d = box_label_q;
    box_xmin_d  = box_xmin_q;
    box_xmax_d  = box_xmax_q;
    box_ymin_d  = box_ymin_q;
    box_ymax_d  = box_ymax_q;
    dump_done_d = 1'b0;
    overrun_d   = overrun_q | (en && (state_q != S_ACCUM));

    case (state_q)
      S_ACCUM: begin
        if (frame_end) state_d = S_DUMP;
      end
      S_DUMP: begin
        if (ptr_q < PTR_W'(MAX_LABELS)) begin
          if (can_adv) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (valid_q[scan_idx]) begin
              box_valid_d = 1'b1;
              box_label_d = LABEL_W'(ptr_q);
              box_xmin_d  = xmin_q[scan_idx];
              box_xmax_d  = xmax_q[scan_idx];
              box_ymin_d  = ymin_q[scan_idx];
              box_ymax_d  = ymax_q[scan_idx];
            end else begin
              box_valid_d = 1'b0;
              if (ptr_q == PTR_W'(MAX_LABELS - 1)) state_d = S_CLEAR;
            end
          end
        end else if (can_adv) begin
          box_valid_d = 1'b0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ptr_d       = PTR_W'(1);
        box_valid_d = 1'b0;
        dump_done_d = 1'b1;
        state_d     = S_ACCUM;
      end
      default: begin
        state_d = S_ACCUM;
      end
    endcase
  end

  assign box_valid = box_valid_q;
  assign box_label = box_label_q;
  assign box_xmin  = box_xmin_q;
  assign box_xmax  = box_xmax_q;
  assign box_ymin  = box_ymin_q;
  assign box_ymax  = box_ymax_q;
  assign dump_done = dump_done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_bounding_box_tracker.sv
// Directed bench for bounding_box_tracker (default parameters).
module tb_bounding_box_tracker;

  logic        clk = 1'b0;
  logic        reset, en, frame_end, box_ready;
  logic [7:0]  label;
  logic [10:0] x, y;
  logic        box_valid, dump_done, overrun;
  logic [7:0]  box_label;
  logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;

  bounding_box_tracker dut (
    .clk(clk), .reset(reset), .en(en), .label(label), .x(x), .y(y),
    .frame_end(frame_end), .box_valid(box_valid), .box_ready(box_ready),
    .box_label(box_label), .box_xmin(box_xmin), .box_xmax(box_xmax),
    .box_ymin(box_ymin), .box_ymax(box_ymax), .dump_done(dump_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lbl; int xmin; int xmax; int ymin; int ymax; int cyc;
  } rec_t;

  rec_t recs[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  int   fe_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  // Accepted-record and dump_done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    rec_t r;
    if (!reset && box_valid && box_ready) begin
      r.lbl = box_label; r.xmin = box_xmin; r.xmax = box_xmax;
      r.ymin = box_ymin; r.ymax = box_ymax; r.cyc = cyc;
      recs.push_back(r);
    end
    if (dump_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  task automatic pixel(input int l, input int px, input int py);
    en = 1'b1; label = 8'(l); x = 11'(px); y = 11'(py);
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    fe_cyc = cyc;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start;
    bit seen;
    start = done_cnt;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (done_cnt != start) begin seen = 1; break; end
    end
    #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: dump_done got 0 pulses, expected 1", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; frame_end = 1'b0; box_ready = 1'b1;
    label = '0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (box_valid !== 1'b0) begin errors++; $display("FAIL reset_box_valid: got %0b expected 0", box_valid); end
    checks++; if (dump_done !== 1'b0) begin errors++; $display("FAIL reset_dump_done: got %0b expected 0", dump_done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    checks++; if ({box_label, box_xmin, box_xmax, box_ymin, box_ymax} !== '0) begin
      errors++; $display("FAIL reset_box_data: got label %0d x %0d..%0d y %0d..%0d expected all 0",
                         box_label, box_xmin, box_xmax, box_ymin, box_ymax);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_label();
    recs.delete();
    box_ready = 1'b1;
    pixel(5, 10, 20); pixel(5, 3, 40); pixel(5, 15, 7);
    pulse_fe();
    wait_done("single");
    checks++; if (recs.size() != 1) begin errors++; $display("FAIL single_count: got %0d records expected 1", recs.size()); end
    else begin
      checks++;
      if (recs[0].lbl != 5 || recs[0].xmin != 3 || recs[0].xmax != 15 || recs[0].ymin != 7 || recs[0].ymax != 40) begin
        errors++; $display("FAIL single_record: got {%0d,%0d,%0d,%0d,%0d} expected {5,3,15,7,40}",
                           recs[0].lbl, recs[0].xmin, recs[0].xmax, recs[0].ymin, recs[0].ymax);
      end
    end
  endtask

  task automatic test_two_labels();
    int d0;
    recs.delete();
    d0 = done_cnt;
    pixel(9, 100, 200); pixel(2, 1, 1);
    pulse_fe();
    wait_done("two");
    repeat (5) @(posedge clk); #1;
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL two_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (recs.size() != 2) begin errors++; $display("FAIL two_count: got %0d records expected 2", recs.size()); end
    else begin
      checks++;
      if (recs[0].lbl != 2 || recs[0].xmin != 1 || recs[0].xmax != 1 || recs[0].ymin != 1 || recs[0].ymax != 1) begin
        errors++; $display("FAIL two_rec0: got {%0d,%0d,%0d,%0d,%0d} expected {2,1,1,1,1}",
                           recs[0].lbl, recs[0].xmin, recs[0].xmax, recs[0].ymin, recs[0].ymax);
      end
      checks++;
      if (recs[1].lbl != 9 || recs[1].xmin != 100 || recs[1].xmax != 100 || recs[1].ymin != 200 || recs[1].ymax != 200) begin
        errors++; $display("FAIL two_rec1: got {%0d,%0d,%0d,%0d,%0d} expected {9,100,100,200,200}",
                           recs[1].lbl, recs[1].xmin, recs[1].xmax, recs[1].ymin, recs[1].ymax);
      end
    end
  endtask

  task automatic test_back_to_back();
    recs.delete();
    pixel(10, 4, 4); pixel(11, 5, 5); pixel(12, 6, 6);
    pulse_fe();
    wait_done("b2b");
    checks++; if (recs.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d records expected 3", recs.size()); end
    else begin
      checks++;
      if (recs[0].lbl != 10 || recs[1].lbl != 11 || recs[2].lbl != 12) begin
        errors++; $display("FAIL b2b_order: got %0d,%0d,%0d expected 10,11,12", recs[0].lbl, recs[1].lbl, recs[2].lbl);
      end
      checks++;
      if (recs[1].cyc - recs[0].cyc != 1 || recs[2].cyc - recs[1].cyc != 1) begin
        errors++; $display("FAIL b2b_spacing: got gaps %0d,%0d expected 1,1",
                           recs[1].cyc - recs[0].cyc, recs[2].cyc - recs[1].cyc);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0]  s_lbl;
    logic [10:0] s_x0, s_x1, s_y0, s_y1;
    bit seen, held;
    recs.delete();
    pixel(2, 1, 1); pixel(9, 100, 200);
    box_ready = 1'b0;
    pulse_fe();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (box_valid) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_valid_timeout: box_valid got 0 expected 1"); end
    s_lbl = box_label; s_x0 = box_xmin; s_x1 = box_xmax; s_y0 = box_ymin; s_y1 = box_ymax;
    checks++; if (s_lbl !== 8'd2) begin errors++; $display("FAIL stall_first_label: got %0d expected 2", s_lbl); end
    held = 1;
    repeat (5) begin
      @(negedge clk);
      if (box_valid !== 1'b1 || box_label !== s_lbl || box_xmin !== s_x0 || box_xmax !== s_x1 ||
          box_ymin !== s_y0 || box_ymax !== s_y1) held = 0;
    end
    checks++; if (!held) begin errors++; $display("FAIL stall_hold: got record changed during stall expected stable"); end
    @(posedge clk); #1;
    box_ready = 1'b1;
    wait_done("stall");
    checks++; if (recs.size() != 2) begin errors++; $display("FAIL stall_count: got %0d records expected 2", recs.size()); end
    else begin
      checks++;
      if (recs[0].lbl != 2 || recs[0].xmax != 1 || recs[1].lbl != 9 || recs[1].xmin != 100 || recs[1].ymax != 200) begin
        errors++; $display("FAIL stall_records: got labels %0d,%0d expected 2,9 with correct extents",
                           recs[0].lbl, recs[1].lbl);
      end
    end
  endtask

  task automatic test_empty();
    recs.delete();
    pixel(0, 5, 5); pixel(70, 6, 6);
    pulse_fe();
    wait_done("empty");
    checks++; if (recs.size() != 0) begin errors++; $display("FAIL empty_count: got %0d records expected 0", recs.size()); end
    checks++; if (last_done_cyc - fe_cyc != 65) begin
      errors++; $display("FAIL empty_latency: got %0d cycles expected 65", last_done_cyc - fe_cyc);
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL empty_overrun: got %0b expected 0", overrun); end
  endtask

  task automatic test_overrun();
    int d0;
    recs.delete();
    pixel(5, 50, 50);
    pulse_fe();
    @(posedge clk); #1;
    pixel(5, 1, 1);
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    wait_done("ovr_a");
    d0 = done_cnt;
    repeat (80) @(posedge clk); #1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0b expected 1", overrun); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL ovr_no_redump: got %0d extra dump_done expected 0", done_cnt - d0); end
    checks++; if (recs.size() != 1) begin errors++; $display("FAIL ovr_count_a: got %0d records expected 1", recs.size()); end
    else begin
      checks++;
      if (recs[0].lbl != 5 || recs[0].xmin != 50 || recs[0].xmax != 50 || recs[0].ymin != 50 || recs[0].ymax != 50) begin
        errors++; $display("FAIL ovr_rec_a: got {%0d,%0d,%0d,%0d,%0d} expected {5,50,50,50,50}",
                           recs[0].lbl, recs[0].xmin, recs[0].xmax, recs[0].ymin, recs[0].ymax);
      end
    end
    recs.delete();
    pixel(5, 30, 60);
    pulse_fe();
    wait_done("ovr_b");
    checks++; if (recs.size() != 1) begin errors++; $display("FAIL ovr_count_b: got %0d records expected 1", recs.size()); end
    else begin
      checks++;
      if (recs[0].lbl != 5 || recs[0].xmin != 30 || recs[0].xmax != 30 || recs[0].ymin != 60 || recs[0].ymax != 60) begin
        errors++; $display("FAIL ovr_rec_b: got {%0d,%0d,%0d,%0d,%0d} expected {5,30,30,60,60}",
                           recs[0].lbl, recs[0].xmin, recs[0].xmax, recs[0].ymin, recs[0].ymax);
      end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0b expected 1", overrun); end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit seen;
    recs.delete();
    box_ready = 1'b1;
    pixel(3, 10, 11); pixel(4, 12, 13); pixel(6, 14, 15);
    pulse_fe();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (box_valid && box_label == 8'd3) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_first_timeout: record 3 got none expected one"); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (box_valid !== 1'b0) begin errors++; $display("FAIL rst_abort: box_valid got %0b expected 0", box_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (recs.size() != 1 || recs[0].lbl != 3) begin
      errors++; $display("FAIL rst_pre_records: got %0d records expected 1 (label 3)", recs.size());
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun_clear: got %0b expected 0", overrun); end
    recs.delete();
    d0 = done_cnt;
    repeat (80) @(posedge clk); #1;
    checks++; if (done_cnt != d0 || recs.size() != 0) begin
      errors++; $display("FAIL rst_quiet: got %0d dump_done and %0d records expected 0 and 0", done_cnt - d0, recs.size());
    end
    pixel(7, 8, 9);
    pulse_fe();
    wait_done("rst_next");
    checks++; if (recs.size() != 1) begin errors++; $display("FAIL rst_next_count: got %0d records expected 1", recs.size()); end
    else begin
      checks++;
      if (recs[0].lbl != 7 || recs[0].xmin != 8 || recs[0].xmax != 8 || recs[0].ymin != 9 || recs[0].ymax != 9) begin
        errors++; $display("FAIL rst_next_rec: got {%0d,%0d,%0d,%0d,%0d} expected {7,8,8,9,9}",
                           recs[0].lbl, recs[0].xmin, recs[0].xmax, recs[0].ymin, recs[0].ymax);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_label();
    test_two_labels();
    test_back_to_back();
    test_stall();
    test_empty();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
